bcd_scoreboard_n: RTL and testbench
===================================

Name: bcd_scoreboard_n

Overview:
Parametrised successor to the two-digit scoreboard. It is an N-digit BCD up/down score counter with single-cycle increment and decrement pulses, and a hold-to-erase controller that clears only after erase is held for a programmed number of cycles. The block has a selectable saturate or wrap mode, overflow and underflow event pulses, optional leading-zero blanking, and per-digit active-high 7-segment outputs. It sits between the debounced button/pulse logic and the display pins.

Parameters:
DIGITS, 2, number of BCD digits (1..8); the maximum score is 10^DIGITS - 1.
ERASE_HOLD, 4, consecutive cycles erase_i must be high before the score clears (1..255).
SATURATE, 1, selects the limit behaviour: 1 clamps at 0 and at the maximum; 0 wraps max->0 and 0->max.
BLANK_LZ, 0, when 1, leading-zero digits above digit 0 drive all-off segments.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-low reset.
inc_i  input  1  increment request, sampled each rising edge.
dec_i  input  1  decrement request, sampled each rising edge.
erase_i  input  1  erase request; must be held high to take effect.
bcd_o  output  4*DIGITS  registered score; digit k is in [4k+3:4k], digit 0 is the units digit.
seg_o  output  7*DIGITS  7-segment pattern; digit k is in [7k+6:7k], bit order a..g = bit 6..bit 0, active-high.
zero_o  output  1  high when the score is 0.
max_o  output  1  high when the score is at the maximum.
ovf_o  output  1  one-cycle pulse when an increment is applied at the maximum.
unf_o  output  1  one-cycle pulse when a decrement is applied at 0.
erasing_o  output  1  high while the controller is in ERASE_CNT.

Behaviour:
- Reset (rst low, asynchronous):
  - score = 0; state = IDLE; hold counter = 0.
  - ovf_o = unf_o = 0; erasing_o = 0.
  - zero_o = 1; max_o = 0.
  - seg_o shows the pattern for digit 0 on every digit (7'h7E each), or all-off above digit 0 when BLANK_LZ = 1.
- Release of reset is effective at the first rising edge after rst goes high.
- Counter update, one-cycle latency: a request sampled at edge k changes bcd_o at edge k. zero_o, max_o and seg_o decode combinationally from the registered score.
- Request priority:
  - erase_i high: inc_i and dec_i are ignored.
  - inc_i and dec_i both high: no change and no pulse.
  - inc_i only: score+1 in BCD, with the digit carry 9->0 propagating to the next digit.
  - dec_i only: score-1, with the borrow 0->9 propagating to the next digit.
- At the maximum, inc_i:
  - SATURATE = 1: the score holds.
  - SATURATE = 0: the score becomes 0.
  - In both modes, ovf_o = 1 for exactly one cycle.
- At 0, dec_i:
  - SATURATE = 1: the score holds.
  - SATURATE = 0: the score becomes the maximum.
  - In both modes, unf_o = 1 for exactly one cycle.
- Erase FSM:
  - IDLE: when erase_i is sampled high, go to ERASE_CNT with hold counter = 1.
  - ERASE_CNT:
    - erase_i low: go to IDLE, clear the hold counter, leave the score unchanged.
    - erase_i high and counter < ERASE_HOLD: increment the counter.
    - The edge on which the counter would reach ERASE_HOLD, with erase_i high: score <- 0, go to WAIT_REL.
    - With ERASE_HOLD = 1, the clear happens on the first high sample; go directly to WAIT_REL.
  - WAIT_REL: stay while erase_i is high, with no further clears; go to IDLE on the first low sample. inc_i and dec_i are also ignored during the release cycle.
  - erasing_o = 1 only in ERASE_CNT.
- Erase has no effect on ovf_o or unf_o.
- 7-segment encoding, digits 0..9: 7E 30 6D 79 33 5B 5F 70 7F 7B (hex). Non-BCD values cannot occur; decode them to 7'h00.
- Leading-zero blanking (BLANK_LZ = 1): digit k>0 is blanked if it and all higher digits are 0. Digit 0 is never blanked.
- Reset asserted mid-erase or mid-pulse: all state is cleared immediately, with no pending clear afterwards.

Test Plan:
1. Reset low then high, DIGITS=2 -> bcd_o=8'h00, seg_o={7E,7E}, zero_o=1, ovf_o=unf_o=0, erasing_o=0.
2. Ten single-cycle inc_i pulses from 0 -> bcd_o=8'h10, seg_o={30,7E}. Then one dec_i -> bcd_o=8'h09, seg_o={7E,7B}. inc_i and dec_i together -> bcd_o unchanged.
3. SATURATE=1 at 99:
   - inc_i -> bcd_o stays 8'h99, ovf_o pulses one cycle, max_o=1.
   - Erase, then dec_i at 0 -> bcd_o=8'h00, unf_o pulses.
   - SATURATE=0 repeats: inc_i gives 00, dec_i gives 99, with the same pulses.
4. Score 8'h42, ERASE_HOLD=4:
   - erase_i high for 3 cycles then low -> score stays 8'h42, erasing_o high for those cycles.
   - erase_i high for 7 cycles -> score 8'h00 on the 4th edge. inc_i during erase is ignored; no second clear before release.
5. BLANK_LZ=1, score 05, DIGITS=3 -> seg_o={00,00,5B}. Score 100 -> seg_o={30,7E,7E}.
6. Score 8'h37 in ERASE_CNT, then assert rst mid-cycle -> outputs take reset values immediately. After release, erase_i low -> FSM in IDLE, no clear.

Source files
------------

// File: rtl/bcd_scoreboard_n.sv
// N-digit BCD up/down score counter with hold-to-erase, saturate/wrap limits and 7-segment decode.
// Latency: one cycle from a sampled request to bcd_o/ovf_o/unf_o; zero_o, max_o and seg_o decode the registered score.
// Backpressure: none; every request is consumed on the edge it is sampled, and requests not applied are dropped.
module bcd_scoreboard_n #(
    parameter int unsigned DIGITS     = 2,
    parameter int unsigned ERASE_HOLD = 4,
    parameter int unsigned SATURATE   = 1,
    parameter int unsigned BLANK_LZ   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inc_i,
    input  logic                  dec_i,
    input  logic                  erase_i,
    output logic [4*DIGITS-1:0]   bcd_o,
    output logic [7*DIGITS-1:0]   seg_o,
    output logic                  zero_o,
    output logic                  max_o,
    output logic                  ovf_o,
    output logic                  unf_o,
    output logic                  erasing_o
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ERASE_CNT = 2'd1,
        WAIT_REL  = 2'd2
    } state_t;

    localparam logic [8:0]          HOLD_LIM = 9'(ERASE_HOLD);
    localparam logic [4*DIGITS-1:0] MAX_VAL  = {DIGITS{4'h9}};

    state_t              state_q, state_d;
    logic [7:0]          hold_q, hold_d;
    logic [4*DIGITS-1:0] score_q, score_d, score_inc, score_dec;
    logic                ovf_q, ovf_d, unf_q, unf_d;
    logic                clear, req_ok, do_inc, do_dec;
    logic                inc_carry, dec_borrow, lz_run;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h7E;
            4'd1:    seg7 = 7'h30;
            4'd2:    seg7 = 7'h6D;
            4'd3:    seg7 = 7'h79;
            4'd4:    seg7 = 7'h33;
            4'd5:    seg7 = 7'h5B;
            4'd6:    seg7 = 7'h5F;
            4'd7:    seg7 = 7'h70;
            4'd8:    seg7 = 7'h7F;
            4'd9:    seg7 = 7'h7B;
            default: seg7 = 7'h00;
        endcase
    endfunction

    assign zero_o    = (score_q == '0);
    assign max_o     = (score_q == MAX_VAL);
    assign bcd_o     = score_q;
    assign ovf_o     = ovf_q;
    assign unf_o     = unf_q;
    assign erasing_o = (state_q == ERASE_CNT);

    // Ripple carry/borrow across digits; wrap at the limits is handled separately.
    always_comb begin
        inc_carry = 1'b1;
        score_inc = score_q;
        for (int k = 0; k < int'(DIGITS); k++) begin
            if (inc_carry) begin
                if (score_q[4*k +: 4] == 4'd9) begin
                    score_inc[4*k +: 4] = 4'd0;
                end else begin
                    score_inc[4*k +: 4] = score_q[4*k +: 4] + 4'd1;
                    inc_carry           = 1'b0;
                end
            end
        end
    end

    always_comb begin
        dec_borrow = 1'b1;
        score_dec  = score_q;
        for (int k = 0; k < int'(DIGITS); k++) begin
            if (dec_borrow) begin
                if (score_q[4*k +: 4] == 4'd0) begin
                    score_dec[4*k +: 4] = 4'd9;
                end else begin
                    score_dec[4*k +: 4] = score_q[4*k +: 4] - 4'd1;
                    dec_borrow          = 1'b0;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        clear   = 1'b0;
        case (state_q)
            IDLE: begin
                if (erase_i) begin
                    if (ERASE_HOLD <= 1) begin
                        clear   = 1'b1;
                        state_d = WAIT_REL;
                        hold_d  = 8'd0;
                    end else begin
                        state_d = ERASE_CNT;
                        hold_d  = 8'd1;
                    end
                end
            end
            ERASE_CNT: begin
                if (!erase_i) begin
                    state_d = IDLE;
                    hold_d  = 8'd0;
                end else if (({1'b0, hold_q} + 9'd1) >= HOLD_LIM) begin
                    clear   = 1'b1;
                    state_d = WAIT_REL;
                    hold_d  = 8'd0;
                end else begin
                    hold_d = hold_q + 8'd1;
                end
            end
            WAIT_REL: begin
                if (!erase_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                hold_d  = 8'd0;
            end
        endcase
    end

    // Counting only happens with the erase controller fully idle, so the
    // release edge and an aborted hold never also move the score.
    assign req_ok = (state_q == IDLE) && !erase_i;
    assign do_inc = req_ok && inc_i && !dec_i;
    assign do_dec = req_ok && dec_i && !inc_i;

    always_comb begin
        score_d = score_q;
        ovf_d   = do_inc && max_o;
        unf_d   = do_dec && zero_o;
        if (clear) begin
            score_d = '0;
        end else if (do_inc) begin
            if (max_o) begin
                score_d = (SATURATE != 0) ? score_q : '0;
            end else begin
                score_d = score_inc;
            end
        end else if (do_dec) begin
            if (zero_o) begin
                score_d = (SATURATE != 0) ? score_q : MAX_VAL;
            end else begin
                score_d = score_dec;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            hold_q  <= 8'd0;
            score_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            score_q <= score_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Scan from the top digit down; lz_run stays set while every digit seen so far is zero.
    always_comb begin
        lz_run = 1'b1;
        seg_o  = '0;
        for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
            lz_run = lz_run && (score_q[4*k +: 4] == 4'd0);
            if ((BLANK_LZ != 0) && (k > 0) && lz_run) begin
                seg_o[7*k +: 7] = 7'h00;
            end else begin
                seg_o[7*k +: 7] = seg7(score_q[4*k +: 4]);
            end
        end
    end

endmodule

// File: tb/tb_bcd_scoreboard_n.sv
// Bench for bcd_scoreboard_n: three configurations share one stimulus stream and are
// compared every cycle against an integer-score model, plus hand-computed literal checks.
module tb_bcd_scoreboard_n;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic inc = 1'b0;
    logic dec = 1'b0;
    logic erase = 1'b0;

    logic [7:0]  bcd_a, bcd_b;
    logic [11:0] bcd_c;
    logic [13:0] seg_a, seg_b;
    logic [20:0] seg_c;
    logic [2:0]  zero_v, max_v, ovf_v, unf_v, ers_v;

    int pass_cnt = 0;
    int total_cnt = 0;

    int m_score [3];
    int m_run   [3];
    bit m_ovf   [3];
    bit m_unf   [3];

    always #5 clk = ~clk;

    // a: 2 digits, hold 4, saturate.  b: 2 digits, hold 1, wrap.  c: 3 digits, hold 4, saturate, blanking.
    bcd_scoreboard_n #(.DIGITS(2), .ERASE_HOLD(4), .SATURATE(1), .BLANK_LZ(0)) u_a (
        .clk(clk), .rst(rst), .inc_i(inc), .dec_i(dec), .erase_i(erase),
        .bcd_o(bcd_a), .seg_o(seg_a), .zero_o(zero_v[0]), .max_o(max_v[0]),
        .ovf_o(ovf_v[0]), .unf_o(unf_v[0]), .erasing_o(ers_v[0]));

    bcd_scoreboard_n #(.DIGITS(2), .ERASE_HOLD(1), .SATURATE(0), .BLANK_LZ(0)) u_b (
        .clk(clk), .rst(rst), .inc_i(inc), .dec_i(dec), .erase_i(erase),
        .bcd_o(bcd_b), .seg_o(seg_b), .zero_o(zero_v[1]), .max_o(max_v[1]),
        .ovf_o(ovf_v[1]), .unf_o(unf_v[1]), .erasing_o(ers_v[1]));

    bcd_scoreboard_n #(.DIGITS(3), .ERASE_HOLD(4), .SATURATE(1), .BLANK_LZ(1)) u_c (
        .clk(clk), .rst(rst), .inc_i(inc), .dec_i(dec), .erase_i(erase),
        .bcd_o(bcd_c), .seg_o(seg_c), .zero_o(zero_v[2]), .max_o(max_v[2]),
        .ovf_o(ovf_v[2]), .unf_o(unf_v[2]), .erasing_o(ers_v[2]));

    function automatic int p_dig(input int i);
        return (i == 2) ? 3 : 2;
    endfunction
    function automatic int p_hold(input int i);
        return (i == 1) ? 1 : 4;
    endfunction
    function automatic bit p_sat(input int i);
        return (i != 1);
    endfunction
    function automatic bit p_blank(input int i);
        return (i == 2);
    endfunction

    function automatic int p10(input int k);
        int r = 1;
        for (int j = 0; j < k; j++) r = r * 10;
        return r;
    endfunction

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'h7E;
            1: return 7'h30;
            2: return 7'h6D;
            3: return 7'h79;
            4: return 7'h33;
            5: return 7'h5B;
            6: return 7'h5F;
            7: return 7'h70;
            8: return 7'h7F;
            9: return 7'h7B;
            default: return 7'h00;
        endcase
    endfunction

    function automatic logic [63:0] bcd_of(input int v, input int nd);
        logic [63:0] r = '0;
        for (int k = 0; k < nd; k++) r[4*k +: 4] = 4'((v / p10(k)) % 10);
        return r;
    endfunction

    function automatic logic [63:0] segs_of(input int v, input int nd, input bit blank);
        logic [63:0] r = '0;
        for (int k = 0; k < nd; k++) begin
            if (blank && k > 0 && v < p10(k)) r[7*k +: 7] = 7'h00;
            else r[7*k +: 7] = seg_of((v / p10(k)) % 10);
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    // Model: an integer score plus the length of the current run of erase-high samples.
    always @(posedge clk or negedge rst) begin
        for (int i = 0; i < 3; i++) begin
            int s, r, maxv;
            bit o, u;
            s = m_score[i];
            r = m_run[i];
            o = 1'b0;
            u = 1'b0;
            maxv = p10(p_dig(i)) - 1;
            if (!rst) begin
                s = 0;
                r = 0;
            end else begin
                if (!erase && r == 0 && inc && !dec) begin
                    if (s == maxv) begin
                        o = 1'b1;
                        if (!p_sat(i)) s = 0;
                    end else s = s + 1;
                end else if (!erase && r == 0 && dec && !inc) begin
                    if (s == 0) begin
                        u = 1'b1;
                        if (!p_sat(i)) s = maxv;
                    end else s = s - 1;
                end
                if (erase) begin
                    if (r < 1000) r = r + 1;
                    if (r == p_hold(i)) s = 0;
                end else r = 0;
            end
            m_score[i] <= s;
            m_run[i]   <= r;
            m_ovf[i]   <= o;
            m_unf[i]   <= u;
        end
    end

    task automatic chk_inst(input int i, input logic [63:0] ab, input logic [63:0] as);
        int nd;
        nd = p_dig(i);
        chk($sformatf("bcd%0d", i), ab, bcd_of(m_score[i], nd));
        chk($sformatf("seg%0d", i), as, segs_of(m_score[i], nd, p_blank(i)));
        chk($sformatf("zero%0d", i), 64'(zero_v[i]), 64'(m_score[i] == 0));
        chk($sformatf("max%0d", i), 64'(max_v[i]), 64'(m_score[i] == p10(nd) - 1));
        chk($sformatf("ovf%0d", i), 64'(ovf_v[i]), 64'(m_ovf[i]));
        chk($sformatf("unf%0d", i), 64'(unf_v[i]), 64'(m_unf[i]));
        chk($sformatf("erasing%0d", i), 64'(ers_v[i]), 64'(m_run[i] > 0 && m_run[i] < p_hold(i)));
    endtask

    always @(negedge clk) begin
        chk_inst(0, 64'(bcd_a), 64'(seg_a));
        chk_inst(1, 64'(bcd_b), 64'(seg_b));
        chk_inst(2, 64'(bcd_c), 64'(seg_c));
    end

    task automatic step(input logic i_v, input logic d_v, input logic e_v);
        inc   = i_v;
        dec   = d_v;
        erase = e_v;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic steps(input int n, input logic i_v, input logic d_v, input logic e_v);
        for (int j = 0; j < n; j++) step(i_v, d_v, e_v);
    endtask

    initial begin
        #1 rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        chk("lit_rst_bcd", 64'(bcd_a), 64'h00);
        chk("lit_rst_seg", 64'(seg_a), 64'({7'h7E, 7'h7E}));
        chk("lit_rst_zero", 64'(zero_v[0]), 64'd1);
        chk("lit_rst_ovf_unf", 64'({ovf_v[0], unf_v[0]}), 64'd0);
        chk("lit_rst_erasing", 64'(ers_v[0]), 64'd0);
        chk("lit_rst_seg_blank", 64'(seg_c), 64'({7'h00, 7'h00, 7'h7E}));

        steps(10, 1'b1, 1'b0, 1'b0);
        chk("lit_ten_bcd", 64'(bcd_a), 64'h10);
        chk("lit_ten_seg", 64'(seg_a), 64'({7'h30, 7'h7E}));
        chk("lit_ten_seg_blank", 64'(seg_c), 64'({7'h00, 7'h30, 7'h7E}));
        step(1'b0, 1'b1, 1'b0);
        chk("lit_dec_bcd", 64'(bcd_a), 64'h09);
        chk("lit_dec_seg", 64'(seg_a), 64'({7'h7E, 7'h7B}));
        step(1'b1, 1'b1, 1'b0);
        chk("lit_both_bcd", 64'(bcd_a), 64'h09);

        steps(90, 1'b1, 1'b0, 1'b0);
        chk("lit_99_max", 64'(max_v[0]), 64'd1);
        step(1'b1, 1'b0, 1'b0);
        chk("lit_sat_hold", 64'(bcd_a), 64'h99);
        chk("lit_sat_ovf", 64'(ovf_v[0]), 64'd1);
        chk("lit_wrap_bcd", 64'(bcd_b), 64'h00);
        chk("lit_wrap_ovf", 64'(ovf_v[1]), 64'd1);
        step(1'b0, 1'b0, 1'b0);
        chk("lit_ovf_one_cycle", 64'(ovf_v[0]), 64'd0);

        steps(5, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        chk("lit_erased", 64'(bcd_a), 64'h00);
        step(1'b0, 1'b1, 1'b0);
        chk("lit_sat_floor", 64'(bcd_a), 64'h00);
        chk("lit_sat_unf", 64'(unf_v[0]), 64'd1);
        chk("lit_wrap_under", 64'(bcd_b), 64'h99);
        chk("lit_wrap_unf", 64'(unf_v[1]), 64'd1);
        step(1'b0, 1'b0, 1'b0);

        steps(42, 1'b1, 1'b0, 1'b0);
        chk("lit_42", 64'(bcd_a), 64'h42);
        for (int j = 0; j < 3; j++) begin
            step(1'b0, 1'b0, 1'b1);
            chk("lit_short_erasing", 64'(ers_v[0]), 64'd1);
        end
        step(1'b0, 1'b0, 1'b0);
        chk("lit_short_kept", 64'(bcd_a), 64'h42);
        chk("lit_short_idle", 64'(ers_v[0]), 64'd0);
        steps(3, 1'b1, 1'b0, 1'b1);
        chk("lit_hold3", 64'(bcd_a), 64'h42);
        step(1'b1, 1'b0, 1'b1);
        chk("lit_hold4_clear", 64'(bcd_a), 64'h00);
        chk("lit_hold4_wait", 64'(ers_v[0]), 64'd0);
        steps(3, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        chk("lit_release_ignored", 64'(bcd_a), 64'h00);
        step(1'b1, 1'b0, 1'b0);
        chk("lit_after_release", 64'(bcd_a), 64'h01);

        steps(4, 1'b1, 1'b0, 1'b0);
        chk("lit_blank5_bcd", 64'(bcd_c), 64'h005);
        chk("lit_blank5_seg", 64'(seg_c), 64'({7'h00, 7'h00, 7'h5B}));
        steps(95, 1'b1, 1'b0, 1'b0);
        chk("lit_blank100_seg", 64'(seg_c), 64'({7'h30, 7'h7E, 7'h7E}));

        steps(4, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        steps(37, 1'b1, 1'b0, 1'b0);
        chk("lit_37", 64'(bcd_a), 64'h37);
        steps(2, 1'b0, 1'b0, 1'b1);
        chk("lit_mid_erasing", 64'(ers_v[0]), 64'd1);
        #3 rst = 1'b0;
        #1;
        chk("lit_async_bcd", 64'(bcd_a), 64'h00);
        chk("lit_async_seg", 64'(seg_a), 64'({7'h7E, 7'h7E}));
        chk("lit_async_erasing", 64'(ers_v[0]), 64'd0);
        chk("lit_async_zero", 64'(zero_v[0]), 64'd1);
        @(negedge clk);
        erase = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        steps(3, 1'b0, 1'b0, 1'b0);
        chk("lit_post_rst_bcd", 64'(bcd_a), 64'h00);
        chk("lit_post_rst_erasing", 64'(ers_v[0]), 64'd0);
        step(1'b1, 1'b0, 1'b0);
        chk("lit_post_rst_idle", 64'(bcd_a), 64'h01);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
